// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data memory port controller: loads, word stores, byte read-modify-write
// Registered-output FSM; the memory is word-wide, big-endian, with combinational read data.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int MEM_BYTES   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  localparam logic [3:0]      W_LAST = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR + MEM_BYTES);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  lat_lane;
  logic        lat_byte;
  logic [7:0]  lat_wbyte;

  logic [ADDR_W:0]   addr_ext;
  logic              in_window;
  logic [ADDR_W-1:0] aligned;

  // One extra bit so BASE_ADDR+MEM_BYTES cannot wrap at the top of the address space.
  assign addr_ext  = {1'b0, req_addr};
  assign in_window = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign aligned   = {req_addr[ADDR_W-1:2], 2'b00};

  // Big-endian lanes: byte offset 0 lives in the most significant byte.
  function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] sel);
    logic [DATA_W-1:0] shifted;
    shifted = word >> (DATA_W - 8 - 8 * int'(sel));
    return {{(DATA_W-8){1'b0}}, shifted[7:0]};
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] sel,
                                                   input logic [7:0] bval);
    int                sh;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;
    sh   = DATA_W - 8 - 8 * int'(sel);
    mask = {{(DATA_W-8){1'b0}}, 8'hFF} << sh;
    ins  = {{(DATA_W-8){1'b0}}, bval} << sh;
    return (word & ~mask) | ins;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lat_lane       <= '0;
      lat_byte       <= 1'b0;
      lat_wbyte      <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt       <= '0;
            lat_lane  <= req_addr[1:0];
            lat_byte  <= req_byte;
            lat_wbyte <= req_wdata[7:0];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (!in_window) begin
              // Errors complete without touching the memory port.
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write) begin
              state       <= S_RD;
              mem_address <= aligned;
              mem_read    <= 1'b1;
            end else if (!req_byte) begin
              state          <= S_WR;
              mem_address    <= aligned;
              mem_write_data <= req_wdata;
              mem_write      <= (W_LAST == 4'd0);
            end else begin
              state       <= S_RMW_RD;
              mem_address <= aligned;
              mem_read    <= 1'b1;
            end
          end
        end

        S_RD, S_RMW_RD: begin
          if (cnt == W_LAST) begin
            cnt      <= '0;
            mem_read <= 1'b0;
            if (state == S_RD) begin
              state       <= S_DONE;
              mem_address <= '0;
              resp_valid  <= 1'b1;
              resp_err    <= 1'b0;
              resp_rdata  <= lat_byte ? lane_extract(mem_read_data, lat_lane) : mem_read_data;
            end else begin
              state          <= S_RMW_WR;
              mem_write_data <= lane_merge(mem_read_data, lat_lane, lat_wbyte);
              mem_write      <= (W_LAST == 4'd0);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_WR, S_RMW_WR: begin
          if (cnt == W_LAST) begin
            state          <= S_DONE;
            cnt            <= '0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
            mem_address    <= '0;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
          end else begin
            // Strobe only on the final cycle of the address-setup window.
            cnt       <= cnt + 4'd1;
            mem_write <= ((cnt + 4'd1) == W_LAST);
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          cnt        <= '0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - bench for mem_access_ctrl with WAIT_CYCLES=0 and WAIT_CYCLES=3
// Two instances share clock and reset; each has its own word memory and transaction model.
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  logic mem_clr;

  logic        req_valid[2], req_ready[2], req_write[2], req_byte[2];
  logic        resp_valid[2], resp_err[2], busy[2], mem_read[2], mem_write[2];
  logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
  logic [31:0] mem_address[2], mem_write_data[2], mem_read_data[2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdcnt[2];
  int wrcnt[2];

  mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_byte(req_byte[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]), .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_read_data(mem_read_data[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_byte(req_byte[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]), .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_read_data(mem_read_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memories behind each instance: window 1024..1279, 64 words.
  logic [31:0] bmem [2][64];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_read_data[k] = 32'h0;
      if (mem_address[k] >= 32'd1024 && mem_address[k] < 32'd1280)
        mem_read_data[k] = bmem[k][(mem_address[k] - 32'd1024) >> 2];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr) begin
        for (int i = 0; i < 64; i++) bmem[k][i] <= 32'h0;
      end else if (mem_write[k] && mem_address[k] >= 32'd1024 && mem_address[k] < 32'd1280) begin
        bmem[k][(mem_address[k] - 32'd1024) >> 2] <= mem_write_data[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_read[k] === 1'b1) rdcnt[k] = rdcnt[k] + 1;
      if (mem_write[k] === 1'b1) wrcnt[k] = wrcnt[k] + 1;
    end
  end

  task automatic ck(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int k);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s inst=%0d cyc=%0d got=timeout expected=event", nm, k, cyc);
  endtask

  function automatic int wv(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Transaction-level model: each accepted request becomes a timeline of expected events.
  typedef struct {
    bit          active;
    int          t;
    int          lat;
    bit          err;
    bit          wr;
    bit          by;
    logic [31:0] al;
    int          idx;
    int          wr_rel;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
  } txn_t;

  txn_t        pend[2];
  logic [31:0] mmem [2][64];
  int          m_rel, m_w, m_sh;
  bit          m_idle, m_erd, m_ewr;
  logic [31:0] m_a, m_word;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_w = wv(k);
      if (mem_clr) for (int i = 0; i < 64; i++) mmem[k][i] = 32'h0;
      m_idle = !pend[k].active;
      if (rst) begin
        pend[k].active = 1'b0;
        ck("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
        ck("rst_busy", k, 32'(busy[k]), 32'd0);
        ck("rst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
        ck("rst_resp_rdata", k, resp_rdata[k], 32'd0);
        ck("rst_resp_err", k, 32'(resp_err[k]), 32'd0);
        ck("rst_mem_address", k, mem_address[k], 32'd0);
        ck("rst_mem_write_data", k, mem_write_data[k], 32'd0);
        ck("rst_mem_read", k, 32'(mem_read[k]), 32'd0);
        ck("rst_mem_write", k, 32'(mem_write[k]), 32'd0);
      end else if (pend[k].active) begin
        m_rel = cyc - pend[k].t;
        m_erd = !pend[k].err && (!pend[k].wr || pend[k].by) && (m_rel <= m_w);
        m_ewr = !pend[k].err && pend[k].wr && (m_rel == pend[k].wr_rel);
        ck("busy", k, 32'(busy[k]), 32'd1);
        ck("req_ready", k, 32'(req_ready[k]), 32'd0);
        ck("resp_valid", k, 32'(resp_valid[k]), 32'(m_rel == pend[k].lat));
        ck("mem_read", k, 32'(mem_read[k]), 32'(m_erd));
        ck("mem_write", k, 32'(mem_write[k]), 32'(m_ewr));
        if (m_erd || m_ewr) ck("mem_address", k, mem_address[k], pend[k].al);
        if (m_ewr) begin
          ck("mem_write_data", k, mem_write_data[k], pend[k].exp_wd);
          mmem[k][pend[k].idx] = pend[k].exp_wd;
        end
        if (m_rel == pend[k].lat) begin
          ck("resp_rdata", k, resp_rdata[k], pend[k].exp_rd);
          ck("resp_err", k, 32'(resp_err[k]), 32'(pend[k].err));
          pend[k].active = 1'b0;
        end
      end else begin
        ck("idle_req_ready", k, 32'(req_ready[k]), 32'd1);
        ck("idle_busy", k, 32'(busy[k]), 32'd0);
        ck("idle_resp_valid", k, 32'(resp_valid[k]), 32'd0);
        ck("idle_mem_read", k, 32'(mem_read[k]), 32'd0);
        ck("idle_mem_write", k, 32'(mem_write[k]), 32'd0);
        ck("idle_mem_address", k, mem_address[k], 32'd0);
        ck("idle_mem_write_data", k, mem_write_data[k], 32'd0);
      end
      if (!rst && m_idle && req_valid[k] === 1'b1) begin
        m_a             = req_addr[k];
        pend[k].active  = 1'b1;
        pend[k].t       = cyc + 1;
        pend[k].err     = !(m_a >= 32'd1024 && m_a < 32'd1280);
        pend[k].wr      = req_write[k];
        pend[k].by      = req_byte[k];
        pend[k].al      = {m_a[31:2], 2'b00};
        pend[k].idx     = pend[k].err ? 0 : int'((m_a - 32'd1024) >> 2);
        pend[k].lat     = pend[k].err ? 0 : ((pend[k].wr && pend[k].by) ? 2 * m_w + 2 : m_w + 1);
        pend[k].wr_rel  = pend[k].by ? 2 * m_w + 1 : m_w;
        m_sh            = (3 - int'(m_a[1:0])) * 8;
        m_word          = mmem[k][pend[k].idx];
        if (pend[k].err || pend[k].wr) pend[k].exp_rd = 32'h0;
        else if (pend[k].by)           pend[k].exp_rd = (m_word >> m_sh) & 32'hFF;
        else                           pend[k].exp_rd = m_word;
        if (pend[k].by)
          pend[k].exp_wd = (m_word & ~(32'hFF << m_sh)) | ({24'h0, req_wdata[k][7:0]} << m_sh);
        else
          pend[k].exp_wd = req_wdata[k];
      end
    end
  end

  task automatic drive(input int k, input bit wr, input bit by, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_byte[k]  = by;
    req_addr[k]  = a;
    req_wdata[k] = d;
  endtask

  task automatic wait_accept(input int k, output int ta);
    ta = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) begin
        ta = cyc + 1;
        break;
      end
    end
    if (ta < 0) fail_now("accept_timeout", k);
  endtask

  task automatic wait_resp(input int k, output int tr, output logic [31:0] rd, output logic er);
    tr = -1;
    rd = 32'h0;
    er = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid[k] === 1'b1) begin
        tr = cyc;
        rd = resp_rdata[k];
        er = resp_err[k];
        break;
      end
    end
    if (tr < 0) fail_now("resp_timeout", k);
  endtask

  task automatic issue(input int k, input bit wr, input bit by, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic er);
    int ta, tr;
    @(posedge clk); #2;
    drive(k, wr, by, a, d);
    wait_accept(k, ta);
    @(posedge clk); #2;
    req_valid[k] = 1'b0;
    wait_resp(k, tr, rd, er);
    lat = tr - ta;
    @(posedge clk); #2;
  endtask

  int          lat, ta, tr, ta_b, r0, w0;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_byte[k] = 1'b0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
      rdcnt[k] = 0; wrcnt[k] = 0;
      pend[k].active = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    mem_clr = 1'b0;

    // Word store then unaligned word load, W=0.
    w0 = wrcnt[0];
    issue(0, 1, 0, 32'd1028, 32'hDEADBEEF, lat, rd, er);
    ck("w0_store_latency", 0, 32'(lat), 32'd1);
    ck("w0_store_write_count", 0, 32'(wrcnt[0] - w0), 32'd1);
    ck("w0_store_mem_word", 0, bmem[0][1], 32'hDEADBEEF);
    issue(0, 0, 0, 32'd1030, 32'h0, lat, rd, er);
    ck("w0_load_latency", 0, 32'(lat), 32'd1);
    ck("w0_load_rdata", 0, rd, 32'hDEADBEEF);
    ck("w0_load_err", 0, 32'(er), 32'd0);

    // Byte read-modify-write and byte load.
    issue(0, 1, 0, 32'd1032, 32'h11223344, lat, rd, er);
    issue(0, 1, 1, 32'd1033, 32'h000000AA, lat, rd, er);
    ck("byte_store_latency", 0, 32'(lat), 32'd2);
    ck("byte_store_mem_word", 0, bmem[0][2], 32'h11AA3344);
    issue(0, 0, 1, 32'd1035, 32'h0, lat, rd, er);
    ck("byte_load_rdata", 0, rd, 32'h00000044);

    // Out-of-window requests.
    r0 = rdcnt[0];
    w0 = wrcnt[0];
    issue(0, 0, 0, 32'd1000, 32'h0, lat, rd, er);
    ck("err_load_latency", 0, 32'(lat), 32'd0);
    ck("err_load_err", 0, 32'(er), 32'd1);
    ck("err_load_rdata", 0, rd, 32'h0);
    issue(0, 1, 0, 32'd1280, 32'h12345678, lat, rd, er);
    ck("err_store_latency", 0, 32'(lat), 32'd0);
    ck("err_store_err", 0, 32'(er), 32'd1);
    ck("err_no_mem_read", 0, 32'(rdcnt[0] - r0), 32'd0);
    ck("err_no_mem_write", 0, 32'(wrcnt[0] - w0), 32'd0);

    // Held req_valid with fields changing while busy.
    @(posedge clk); #2;
    drive(0, 0, 0, 32'd1028, 32'h0);
    wait_accept(0, ta);
    @(posedge clk); #2;
    drive(0, 0, 1, 32'd1035, 32'hFFFFFFFF);
    wait_resp(0, tr, rd, er);
    ck("held_first_rdata", 0, rd, 32'hDEADBEEF);
    wait_accept(0, ta_b);
    ck("held_second_accept", 0, 32'(ta_b - tr), 32'd2);
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    wait_resp(0, tr, rd, er);
    ck("held_second_rdata", 0, rd, 32'h00000044);

    // Wait states, W=3.
    issue(1, 1, 0, 32'd1028, 32'hCAFEF00D, lat, rd, er);
    ck("w3_store_latency", 1, 32'(lat), 32'd4);
    r0 = rdcnt[1];
    issue(1, 0, 0, 32'd1028, 32'h0, lat, rd, er);
    ck("w3_load_latency", 1, 32'(lat), 32'd4);
    ck("w3_load_read_cycles", 1, 32'(rdcnt[1] - r0), 32'd4);
    ck("w3_load_rdata", 1, rd, 32'hCAFEF00D);
    issue(1, 1, 0, 32'd1040, 32'h01020304, lat, rd, er);
    w0 = wrcnt[1];
    issue(1, 1, 1, 32'd1043, 32'h000000EE, lat, rd, er);
    ck("w3_byte_store_latency", 1, 32'(lat), 32'd8);
    ck("w3_byte_store_writes", 1, 32'(wrcnt[1] - w0), 32'd1);
    ck("w3_byte_store_mem_word", 1, bmem[1][4], 32'h010203EE);

    // Reset while a byte store is in its read phase.
    issue(1, 1, 0, 32'd1036, 32'h55667788, lat, rd, er);
    @(posedge clk); #2;
    drive(1, 1, 1, 32'd1037, 32'h00000099);
    wait_accept(1, ta);
    @(posedge clk); #3;
    ck("pre_rst_mem_read", 1, 32'(mem_read[1]), 32'd1);
    rst = 1'b1;
    req_valid[1] = 1'b0;
    #1;
    ck("async_rst_mem_read", 1, 32'(mem_read[1]), 32'd0);
    ck("async_rst_busy", 1, 32'(busy[1]), 32'd0);
    ck("async_rst_req_ready", 1, 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    ck("rst_mem_word_kept", 1, bmem[1][3], 32'h55667788);
    issue(1, 0, 0, 32'd1036, 32'h0, lat, rd, er);
    ck("post_rst_load_rdata", 1, rd, 32'h55667788);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
